// File: rtl/imem_loader.sv
// imem_loader -- boot-stream loader for the core's instruction memory.
//
// Accepts a byte stream from the host: a 16-bit word count N (LSB first),
// then N little-endian 32-bit words. Each word is written to the instruction
// memory at consecutive word addresses starting at 0. The core is held in
// reset until a complete image has been loaded.
//
// Optional feature: define LOADER_CHECKSUM_EN to expect one trailing
// checksum byte (XOR of all data bytes) after the data words. A mismatch
// ends in the error state instead of releasing the core.
//
// Ports:
//   clk        in   single clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   in_data holds a valid host byte
//   in_data    in   host boot-stream byte
//   in_ready   out  loader accepts a byte (transfer = in_valid & in_ready)
//   reload     in   one-cycle pulse, honoured only in DONE or ERR
//   imem_we    out  instruction-memory write strobe, one cycle per word
//   imem_addr  out  word address of the write
//   imem_wdata out  instruction word to write
//   cpu_rst    out  active-high core reset, low only in DONE
//   busy       out  loading in progress
//   done       out  image loaded
//   error      out  stream rejected
module imem_loader #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  input  logic                  reload,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_rst,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  typedef enum logic [2:0] {
    S_HDR_LO,
    S_HDR_HI,
    S_DATA,
`ifdef LOADER_CHECKSUM_EN
    S_CHECK,
`endif
    S_DONE,
    S_ERR
  } state_t;

  // State entered once the last data word (or an empty image) is accepted.
`ifdef LOADER_CHECKSUM_EN
  localparam state_t S_END = S_CHECK;
`else
  localparam state_t S_END = S_DONE;
`endif

  // Largest legal word count: the full memory, 2^ADDR_WIDTH words.
  localparam logic [16:0]         MAX_WORDS = 17'(1) << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] IDX_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_t                state_q, state_d;
  logic [7:0]            n_lo_q;
  logic [ADDR_WIDTH:0]   n_q;      // word count, fits because N <= 2^ADDR_WIDTH
  logic [ADDR_WIDTH:0]   widx_q;   // one extra bit so a full image does not wrap
  logic [1:0]            bcnt_q;
  logic [23:0]           wbuf_q;   // first three bytes of the word in progress
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]            csum_q;
`endif
  logic                  imem_we_q;
  logic [ADDR_WIDTH-1:0] imem_addr_q;
  logic [31:0]           imem_wdata_q;
  logic                  cpu_rst_q, busy_q, in_ready_q, done_q, error_q;

  logic                  accept;
  logic [15:0]           n_full;
  logic [ADDR_WIDTH:0]   widx_inc;
  logic                  last_word;

  assign accept    = in_valid & in_ready_q;
  assign n_full    = {in_data, n_lo_q};
  assign widx_inc  = widx_q + IDX_ONE;
  assign last_word = (widx_inc == n_q);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_HDR_LO: if (accept) state_d = S_HDR_HI;
      S_HDR_HI: begin
        if (accept) begin
          if ({1'b0, n_full} > MAX_WORDS) state_d = S_ERR;
          else if (n_full == 16'd0)       state_d = S_END;
          else                            state_d = S_DATA;
        end
      end
      S_DATA: if (accept && bcnt_q == 2'd3 && last_word) state_d = S_END;
`ifdef LOADER_CHECKSUM_EN
      S_CHECK: if (accept) state_d = (in_data == csum_q) ? S_DONE : S_ERR;
`endif
      S_DONE, S_ERR: if (reload) state_d = S_HDR_LO;
      default: state_d = S_HDR_LO;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_HDR_LO;
      n_lo_q       <= '0;
      n_q          <= '0;
      widx_q       <= '0;
      bcnt_q       <= '0;
      wbuf_q       <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum_q       <= '0;
`endif
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      cpu_rst_q    <= 1'b1;
      busy_q       <= 1'b1;
      in_ready_q   <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      imem_we_q <= 1'b0;

      // Status outputs are registered from the next state so they change
      // on the same edge as the state itself.
      cpu_rst_q  <= (state_d != S_DONE);
      busy_q     <= (state_d != S_DONE) && (state_d != S_ERR);
      in_ready_q <= (state_d != S_DONE) && (state_d != S_ERR);
      done_q     <= (state_d == S_DONE);
      error_q    <= (state_d == S_ERR);

      case (state_q)
        S_HDR_LO: if (accept) n_lo_q <= in_data;
        S_HDR_HI: if (accept) n_q <= n_full[ADDR_WIDTH:0];
        S_DATA: begin
          if (accept) begin
            bcnt_q <= bcnt_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
            csum_q <= csum_q ^ in_data;
`endif
            case (bcnt_q)
              2'd0: wbuf_q[7:0]   <= in_data;
              2'd1: wbuf_q[15:8]  <= in_data;
              2'd2: wbuf_q[23:16] <= in_data;
              default: begin
                imem_we_q    <= 1'b1;
                imem_addr_q  <= widx_q[ADDR_WIDTH-1:0];
                imem_wdata_q <= {in_data, wbuf_q};
                widx_q       <= widx_inc;
              end
            endcase
          end
        end
        S_DONE, S_ERR: begin
          if (reload) begin
            widx_q <= '0;
            bcnt_q <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum_q <= '0;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign cpu_rst    = cpu_rst_q;
  assign busy       = busy_q;
  assign in_ready   = in_ready_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: scoreboard of expected memory writes, checked
// by an independent monitor, plus end-of-stream status checks.
module tb_imem_loader;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          reload = 1'b0;
  logic          in_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_rst, busy, done, error;

  imem_loader #(.ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .reload     (reload),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_rst    (cpu_rst),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  int          n_checks = 0;
  int          n_fail = 0;
  wr_t         exp_q[$];
  wr_t         mon_e;
  logic [31:0] img[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the next expected write.
  always @(negedge clk) begin
    if (rst_n && imem_we) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got addr=%0h data=%0h expected no write",
                 imem_addr, imem_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", 64'(imem_addr), 64'(mon_e.addr));
        chk("wr_data", 64'(imem_wdata), 64'(mon_e.data));
      end
    end
  end

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int w;
    w = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && w < 20) begin
      @(posedge clk);
      #1;
      w++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: got in_ready=0 expected 1 within 20 cycles");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_cpu_rst"},  64'(cpu_rst), 64'd1);
    chk({tag, "_busy"},     64'(busy), 64'd1);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    chk({tag, "_done"},     64'(done), 64'd0);
    chk({tag, "_error"},    64'(error), 64'd0);
    chk({tag, "_we"},       64'(imem_we), 64'd0);
    chk({tag, "_addr"},     64'(imem_addr), 64'd0);
    chk({tag, "_wdata"},    64'(imem_wdata), 64'd0);
  endtask

  // Reload pulse with a simultaneous byte that must be discarded.
  task automatic do_reload();
    reload   = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h05;
    @(posedge clk);
    #1;
    reload   = 1'b0;
    in_valid = 1'b0;
    chk("reload_cpu_rst",  64'(cpu_rst), 64'd1);
    chk("reload_busy",     64'(busy), 64'd1);
    chk("reload_in_ready", 64'(in_ready), 64'd1);
    chk("reload_done",     64'(done), 64'd0);
    chk("reload_error",    64'(error), 64'd0);
  endtask

  task automatic fill_random(input int n);
    img.delete();
    for (int i = 0; i < n; i++) img.push_back($urandom);
  endtask

  // Reference: an image of n words (from img) is valid iff n fits in memory
  // and, when the checksum is in, the trailing byte equals the XOR of data.
  // gapmode: 0 none, 1 random idles, 2 five idle cycles inside word 0.
  task automatic load(input int n, input int gapmode, input bit bad_cs, input bit mid_reload);
    logic [7:0]  cs;
    logic [15:0] nh;
    logic [31:0] w;
    logic [7:0]  b8;
    wr_t         e;
    bit          ok;
    cs = 8'h00;
    nh = n[15:0];
    ok = (n <= (1 << AW));
    send_byte(nh[7:0]);
    send_byte(nh[15:8]);
    if (ok) begin
      for (int i = 0; i < n; i++) begin
        w = img[i];
        e.addr = i[AW-1:0];
        e.data = w;
        exp_q.push_back(e);
        for (int b = 0; b < 4; b++) begin
          b8 = w[8*b +: 8];
          cs = cs ^ b8;
          send_byte(b8);
          if (gapmode == 1) idle($urandom_range(0, 2));
          if (gapmode == 2 && i == 0 && b == 1) idle(5);
          if (mid_reload && i == 0 && b == 1) begin
            reload = 1'b1;
            @(posedge clk);
            #1;
            reload = 1'b0;
          end
        end
      end
`ifdef LOADER_CHECKSUM_EN
      send_byte(cs ^ {7'b0, bad_cs});
      ok = !bad_cs;
`endif
    end
    idle(2);
    chk("writes_drained", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    chk("end_done",     64'(done), 64'(ok));
    chk("end_error",    64'(error), 64'(!ok));
    chk("end_cpu_rst",  64'(cpu_rst), 64'(!ok));
    chk("end_busy",     64'(busy), 64'd0);
    chk("end_in_ready", 64'(in_ready), 64'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("por");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Known two-instruction image.
    img.delete();
    img.push_back(32'h00100093);
    img.push_back(32'h00300113);
    load(2, 0, 1'b0, 1'b0);

    // Idle gap inside a word, after a reload.
    do_reload();
    fill_random(3);
    load(3, 2, 1'b0, 1'b0);

    // Empty image.
    do_reload();
    load(0, 0, 1'b0, 1'b0);

    // Oversized image.
    do_reload();
    load(1025, 0, 1'b0, 1'b0);

`ifdef LOADER_CHECKSUM_EN
    do_reload();
    img.delete();
    img.push_back(32'h0000006f);
    load(1, 0, 1'b1, 1'b0);
    do_reload();
    load(1, 0, 1'b0, 1'b0);
`endif

    // Random images, some with an ignored mid-load reload.
    for (int k = 0; k < 6; k++) begin
      do_reload();
      fill_random($urandom_range(1, 8));
      load(img.size(), 1, ($urandom_range(0, 3) == 0), k[0]);
    end

    // Reset in the middle of a word aborts the load.
    do_reload();
    send_byte(8'h03);
    send_byte(8'h00);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    rst_n = 1'b0;
    #2;
    check_reset_vals("midrst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    fill_random(2);
    load(2, 1, 1'b0, 1'b0);

    // Full memory: top address written, no wrap.
    do_reload();
    fill_random(1 << AW);
    load(1 << AW, 0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
